// File: rtl/motor_laser_sequencer.sv
// Gates the motor enable on a synchronized, debounced laser beam. The FSM covers arm, run, hold and latched-fault.
// Outputs decode the state register directly. A laser_sig step reaches laser_ok DEB_CYCLES+2 edges after it is first sampled.
module motor_laser_sequencer #(
  parameter int DEB_CYCLES  = 16,
  parameter int ARM_TIMEOUT = 1000000,
  parameter int HOLD_CYCLES = 256,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       laser_sig,
  input  logic       start,
  input  logic       stop,
  input  logic       fault_clr,
  output logic       motor_en,
  output logic       busy,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state_o
);
  localparam int               DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       sync_q;
  logic             laser_s;
  logic             laser_ok;
  logic [DEB_W-1:0] deb_cnt;
  logic [CNT_W-1:0] timer;

  assign laser_s = sync_q[1];

  // laser_ok only flips after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q   <= 2'b00;
      laser_ok <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      sync_q <= {sync_q[0], laser_sig};
      if (laser_s == laser_ok) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        laser_ok <= ~laser_ok;
        deb_cnt  <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      timer      <= '0;
      fault_code <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= ARM;
            timer <= '0;
          end
        end
        ARM: begin
          if (stop) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == ARM_LAST) begin
            state      <= FAULT;
            timer      <= '0;
            fault_code <= 2'd1;
          end else if (laser_ok) begin
            state <= RUN;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            timer <= '0;
          end else if (!laser_ok) begin
            state <= HOLD;
            timer <= '0;
          end
        end
        HOLD: begin
          if (stop) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == HOLD_LAST) begin
            state      <= FAULT;
            timer      <= '0;
            fault_code <= 2'd2;
          end else if (laser_ok) begin
            state <= RUN;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FAULT: begin
          // stop is deliberately ignored here: only an explicit acknowledge leaves FAULT
          if (fault_clr) begin
            state      <= IDLE;
            timer      <= '0;
            fault_code <= 2'd0;
          end
        end
        default: begin
          state <= IDLE;
          timer <= '0;
        end
      endcase
    end
  end

  assign motor_en = (state == RUN);
  assign busy     = (state == ARM) || (state == RUN) || (state == HOLD);
  assign fault    = (state == FAULT);
  assign state_o  = state;

endmodule

// File: tb/tb_motor_laser_sequencer.sv
// Bench for motor_laser_sequencer: vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_motor_laser_sequencer;
  localparam int DEB    = 4;
  localparam int ARM_T  = 100;
  localparam int HOLD_T = 20;

  logic       clk = 1'b0;
  logic       rstn;
  logic       laser_sig;
  logic       start;
  logic       stop;
  logic       fault_clr;
  logic       motor_en;
  logic       busy;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state_o;

  motor_laser_sequencer #(
    .DEB_CYCLES (DEB),
    .ARM_TIMEOUT(ARM_T),
    .HOLD_CYCLES(HOLD_T),
    .CNT_W      (24)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .laser_sig (laser_sig),
    .start     (start),
    .stop      (stop),
    .fault_clr (fault_clr),
    .motor_en  (motor_en),
    .busy      (busy),
    .fault     (fault),
    .fault_code(fault_code),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: states 0..4, dwell = edges spent since entering the current state
  int m_state = 0;
  int m_code  = 0;
  int m_dwell = 0;
  bit m_ok    = 1'b0;
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;
  bit hist[$];

  logic [7:0] dut_pack;
  assign dut_pack = {motor_en, busy, fault, fault_code, state_o};

  function automatic logic [7:0] pack_exp(int st, int code);
    logic [2:0] s3;
    logic [1:0] c2;
    s3 = 3'(st);
    c2 = 2'(code);
    return {st == 2, (st >= 1 && st <= 3), st == 4, c2, s3};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {men,busy,flt,code,st}=%b want %b at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    int  nxt;
    bit  all_diff;
    if (!rstn) begin
      m_state = 0; m_code = 0; m_dwell = 0;
      m_ok = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
      hist.delete();
    end else begin
      nxt = m_state;
      case (m_state)
        0: if (start && !stop) nxt = 1;
        1: begin
          if (stop) nxt = 0;
          else if (m_dwell == ARM_T - 1) begin nxt = 4; m_code = 1; end
          else if (m_ok) nxt = 2;
        end
        2: begin
          if (stop) nxt = 0;
          else if (!m_ok) nxt = 3;
        end
        3: begin
          if (stop) nxt = 0;
          else if (m_dwell == HOLD_T - 1) begin nxt = 4; m_code = 2; end
          else if (m_ok) nxt = 2;
        end
        default: if (fault_clr) begin nxt = 0; m_code = 0; end
      endcase
      m_dwell = (nxt != m_state) ? 0 : m_dwell + 1;
      m_state = nxt;
      // debounced level flips once the last DEB synchronized samples all disagree with it
      hist.push_back(m_s2);
      if (hist.size() > DEB) void'(hist.pop_front());
      if (hist.size() == DEB) begin
        all_diff = 1'b1;
        foreach (hist[k]) if (hist[k] == m_ok) all_diff = 1'b0;
        if (all_diff) begin
          m_ok = ~m_ok;
          hist.delete();
        end
      end
      m_s2 = m_s1;
      m_s1 = laser_sig;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model", dut_pack, pack_exp(m_state, m_code));
  endtask

  task automatic pulse(input int which);
    if (which == 0) start = 1'b1;
    if (which == 1) stop = 1'b1;
    if (which == 2) fault_clr = 1'b1;
    step();
    start = 1'b0; stop = 1'b0; fault_clr = 1'b0;
  endtask

  typedef struct {
    bit r; bit l; bit s; bit p; bit c;
    int es; int ec;
  } vec_t;
  vec_t vecs[15];

  initial begin
    rstn = 1'b0; laser_sig = 1'b1; start = 1'b0; stop = 1'b0; fault_clr = 1'b0;

    // reset, start+stop in IDLE, debounce latency seen via ARM->RUN, stop priority
    vecs[0]  = '{0, 1, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 1, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 1, 0, 0};
    vecs[3]  = '{1, 1, 1, 1, 0, 0, 0};
    vecs[4]  = '{1, 1, 0, 0, 1, 0, 0};
    vecs[5]  = '{1, 1, 1, 0, 0, 1, 0};
    vecs[6]  = '{1, 1, 1, 0, 0, 1, 0};
    vecs[7]  = '{1, 1, 0, 0, 0, 1, 0};
    vecs[8]  = '{1, 1, 0, 0, 0, 1, 0};
    vecs[9]  = '{1, 1, 0, 0, 0, 2, 0};
    vecs[10] = '{1, 1, 0, 0, 0, 2, 0};
    vecs[11] = '{1, 1, 0, 1, 0, 0, 0};
    vecs[12] = '{1, 1, 1, 0, 0, 1, 0};
    vecs[13] = '{1, 1, 0, 0, 0, 2, 0};
    vecs[14] = '{1, 1, 1, 1, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      rstn = vecs[i].r; laser_sig = vecs[i].l; start = vecs[i].s;
      stop = vecs[i].p; fault_clr = vecs[i].c;
      step();
      check($sformatf("vec%0d", i), dut_pack, pack_exp(vecs[i].es, vecs[i].ec));
    end
    start = 1'b0; stop = 1'b0; fault_clr = 1'b0;

    // 3-cycle glitch while arming with no beam: must never reach RUN
    laser_sig = 1'b0;
    repeat (8) step();
    pulse(0);
    check("glitch_arm", dut_pack, pack_exp(1, 0));
    laser_sig = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("glitch_hi", dut_pack, pack_exp(1, 0));
    end
    laser_sig = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      check("glitch_after", dut_pack, pack_exp(1, 0));
    end
    pulse(1);
    check("glitch_stop", dut_pack, pack_exp(0, 0));

    // arm timeout: ARM for 100 cycles, FAULT on the 101st edge; start/stop ignored in FAULT
    pulse(0);
    check("arm_e1", dut_pack, pack_exp(1, 0));
    for (int j = 2; j <= 100; j++) begin
      if (j == 50) start = 1'b1;
      step();
      start = 1'b0;
      check("arm_wait", dut_pack, pack_exp(1, 0));
    end
    step();
    check("arm_timeout", dut_pack, pack_exp(4, 1));
    pulse(0);
    check("fault_start", dut_pack, pack_exp(4, 1));
    pulse(1);
    check("fault_stop", dut_pack, pack_exp(4, 1));
    pulse(2);
    check("fault_clr", dut_pack, pack_exp(0, 0));

    // dropout of 10 cycles: HOLD then back to RUN
    laser_sig = 1'b1;
    repeat (8) step();
    pulse(0);
    check("run_arm", dut_pack, pack_exp(1, 0));
    step();
    check("run_enter", dut_pack, pack_exp(2, 0));
    laser_sig = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) laser_sig = 1'b1;
      step();
      check("dropout_short", dut_pack, pack_exp((i < 7) ? 2 : (i < 17) ? 3 : 2, 0));
    end
    repeat (4) step();

    // dropout of 40 cycles: HOLD expires after 20 cycles into beam-lost fault
    laser_sig = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      check("dropout_long", dut_pack, pack_exp((i < 7) ? 2 : (i < 27) ? 3 : 4, (i < 27) ? 0 : 2));
    end
    laser_sig = 1'b1;
    step();
    check("beam_lost_held", dut_pack, pack_exp(4, 2));
    pulse(2);
    check("beam_lost_clr", dut_pack, pack_exp(0, 0));

    // stop on the same edge as the arm timeout wins
    laser_sig = 1'b0;
    repeat (8) step();
    pulse(0);
    for (int j = 2; j <= 100; j++) step();
    check("arm_last", dut_pack, pack_exp(1, 0));
    pulse(1);
    check("stop_vs_timeout", dut_pack, pack_exp(0, 0));

    // reset in the middle of HOLD
    laser_sig = 1'b1;
    repeat (8) step();
    pulse(0);
    step();
    laser_sig = 1'b0;
    repeat (8) step();
    check("hold_before_rst", dut_pack, pack_exp(3, 0));
    rstn = 1'b0;
    step();
    check("rst_mid_hold", dut_pack, 8'h00);
    rstn = 1'b1;
    step();
    check("rst_release", dut_pack, 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) laser_sig = ~laser_sig;
      start     = ($urandom_range(0, 14) == 0);
      stop      = ($urandom_range(0, 59) == 0);
      fault_clr = ($urandom_range(0, 24) == 0);
      rstn      = ($urandom_range(0, 799) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
